regfile_sb: RTL and testbench
=============================

Name: regfile_sb

Overview:
Parametrised successor to the processor's 32x32 register file. It provides one write port, two combinational read ports and a register-0 hardwire option. It adds a per-register busy scoreboard for multicycle units (mult/div) and a sequenced soft-clear engine. It sits between decode (read/issue) and writeback in the pipeline.

Parameters:
DATA_WIDTH, 32, bits per register
ADDR_WIDTH, 5, register index width; DEPTH = 2**ADDR_WIDTH
ZERO_REG, 1, 1 = register 0 reads 0 and ignores writes and busy-set; 0 = register 0 is an ordinary register

Ports:
clock  in  1  system clock; all state changes on the rising edge
ctrl_reset_n  in  1  asynchronous, active-low reset
ctrl_writeEnable  in  1  write strobe
ctrl_writeReg  in  ADDR_WIDTH  write index
data_writeReg  in  DATA_WIDTH  write data
ctrl_readRegA  in  ADDR_WIDTH  read index A
ctrl_readRegB  in  ADDR_WIDTH  read index B
data_readRegA  out  DATA_WIDTH  read data A (combinational)
data_readRegB  out  DATA_WIDTH  read data B (combinational)
ctrl_setBusy  in  1  mark ctrl_busyReg busy (multicycle op issued)
ctrl_busyReg  in  ADDR_WIDTH  index to mark busy
busy_A  out  1  busy bit of ctrl_readRegA (combinational)
busy_B  out  1  busy bit of ctrl_readRegB (combinational)
ctrl_clear  in  1  start soft-clear sweep (single-cycle pulse)
clearing  out  1  sweep in progress
stall  out  1  busy_A | busy_B | clearing

Behaviour:
- Async reset (ctrl_reset_n=0): all registers 0, all busy bits 0, FSM IDLE, clearing=0. Reads then return 0, and busy_A/busy_B/stall are 0.
- Write: a write is accepted when ctrl_writeEnable=1 and the FSM is IDLE. The register updates on the rising edge, and the new value is visible on reads the following cycle.
- Writes to reg 0 are dropped when ZERO_REG=1.
- An accepted write to reg r clears busy[r] on the same edge.
- Busy-set: ctrl_setBusy=1 in IDLE sets busy[ctrl_busyReg] on the edge. It is ignored for reg 0 when ZERO_REG=1.
- If busy-set and an accepted write hit the same reg in the same cycle, the set wins: busy stays 1 and the data is still written.
- Reads: purely combinational from the array. With ZERO_REG=1, index 0 always reads 0 and its busy bit reads 0.
- FSM states:
  - IDLE: ctrl_clear=1 moves to SWEEP with ptr=1 (ptr=0 if ZERO_REG=0).
  - SWEEP: on each edge, reg[ptr] is set to 0, busy[ptr] is set to 0, and ptr increments. After processing ptr==DEPTH-1, return to IDLE.
- Sweep length is DEPTH-1 cycles (DEPTH if ZERO_REG=0). For the defaults that is 31 cycles.
- clearing=1 in every SWEEP cycle.
- During SWEEP:
  - external writes and busy-sets are ignored (not queued);
  - ctrl_clear is ignored;
  - reads return current array contents, which may be partially cleared.
- Reset asserted mid-sweep aborts the sweep immediately to the reset state.
- ptr is ADDR_WIDTH bits. No wrap beyond DEPTH-1 is possible because the FSM exits first.

Optional Feature:
Macro REGFILE_SB_BYPASS_EN.
- Defined: write-through bypass. If a write is accepted this cycle and ctrl_writeReg equals a read index (nonzero when ZERO_REG=1), that read port returns data_writeReg combinationally. Its busy_x output returns 0 unless ctrl_setBusy targets the same reg this cycle.
- Undefined: no bypass. A read of a register being written returns the old value until the next cycle, and busy_x returns the pre-edge busy bit.

Test Plan:
- Reset then read all 32 indices -> every data_read is 0 and stall=0. Write reg5=0xDEADBEEF; next cycle read A=5 -> 0xDEADBEEF.
- Write reg0=0x12345678 and setBusy reg0 with ZERO_REG=1 -> reg0 reads 0 and busy_A=0 for index 0.
- setBusy reg7; next cycle readA=7 -> busy_A=1, stall=1. Write reg7=0x55 -> next cycle busy_A=0, data 0x55. Same-cycle setBusy+write reg7 -> busy stays 1 and data updates.
- Fill regs 1..31 with their index, pulse ctrl_clear -> clearing=1 for exactly 31 cycles. A write to reg3 issued mid-sweep is dropped, and all regs read 0 afterwards.
- Assert ctrl_reset_n=0 asynchronously mid-sweep (between edges) -> clearing drops immediately, and all regs and busy bits are 0.
- With REGFILE_SB_BYPASS_EN: write reg9=0xA5A5A5A5 with readB=9 in the same cycle -> data_readRegB=0xA5A5A5A5 that cycle. Without the macro -> the old value that cycle, the new value next cycle.

Source files
------------

// File: rtl/regfile_sb.sv
// Register file with per-register busy scoreboard and sequenced soft-clear; optional macro REGFILE_SB_BYPASS_EN adds write-through read bypass.
// Latency: reads/busy combinational, writes visible next cycle; soft-clear sweep takes DEPTH-1 cycles (DEPTH if ZERO_REG=0).
// Backpressure: stall = busy_A | busy_B | clearing; writes, busy-sets and clear requests during a sweep are dropped, not queued.
module regfile_sb #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int ZERO_REG   = 1
) (
  input  logic                  clock,
  input  logic                  ctrl_reset_n,
  input  logic                  ctrl_writeEnable,
  input  logic [ADDR_WIDTH-1:0] ctrl_writeReg,
  input  logic [DATA_WIDTH-1:0] data_writeReg,
  input  logic [ADDR_WIDTH-1:0] ctrl_readRegA,
  input  logic [ADDR_WIDTH-1:0] ctrl_readRegB,
  output logic [DATA_WIDTH-1:0] data_readRegA,
  output logic [DATA_WIDTH-1:0] data_readRegB,
  input  logic                  ctrl_setBusy,
  input  logic [ADDR_WIDTH-1:0] ctrl_busyReg,
  output logic                  busy_A,
  output logic                  busy_B,
  input  logic                  ctrl_clear,
  output logic                  clearing,
  output logic                  stall
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam bit ZR    = (ZERO_REG != 0);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SWEEP = 1'b1;

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX  = ADDR_WIDTH'(DEPTH - 1);
  // Register 0 is never swept when it is hardwired, so the sweep starts one later.
  localparam logic [ADDR_WIDTH-1:0] FIRST_IDX = ZR ? ADDR_WIDTH'(1) : '0;

  logic [DATA_WIDTH-1:0] regs_q [DEPTH];
  logic [DATA_WIDTH-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0]      busy_q, busy_d;
  logic [0:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;

  logic idle;
  logic wr_acc;
  logic set_acc;

  assign idle    = (state_q == IDLE);
  assign wr_acc  = ctrl_writeEnable && idle && !(ZR && (ctrl_writeReg == '0));
  assign set_acc = ctrl_setBusy && idle && !(ZR && (ctrl_busyReg == '0));

  // Next-state: writes and busy updates in IDLE, one register cleared per cycle in SWEEP.
  always_comb begin
    regs_d  = regs_q;
    busy_d  = busy_q;
    state_d = state_q;
    ptr_d   = ptr_q;
    if (state_q == IDLE) begin
      if (wr_acc) begin
        regs_d[ctrl_writeReg] = data_writeReg;
        busy_d[ctrl_writeReg] = 1'b0;
      end
      // Applied after the write so a same-register set keeps the busy bit high.
      if (set_acc) begin
        busy_d[ctrl_busyReg] = 1'b1;
      end
      if (ctrl_clear) begin
        state_d = SWEEP;
        ptr_d   = FIRST_IDX;
      end
    end else begin
      regs_d[ptr_q] = '0;
      busy_d[ptr_q] = 1'b0;
      ptr_d         = ptr_q + ADDR_WIDTH'(1);
      if (ptr_q == LAST_IDX) begin
        state_d = IDLE;
      end
    end
  end

  // State registers; reset aborts any sweep in progress.
  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
      busy_q  <= '0;
      state_q <= IDLE;
      ptr_q   <= '0;
    end else begin
      regs_q  <= regs_d;
      busy_q  <= busy_d;
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Read port A: array lookup, optional same-cycle bypass, hardwired zero register.
  always_comb begin
    data_readRegA = regs_q[ctrl_readRegA];
    busy_A        = busy_q[ctrl_readRegA];
`ifdef REGFILE_SB_BYPASS_EN
    if (wr_acc && (ctrl_writeReg == ctrl_readRegA)) begin
      data_readRegA = data_writeReg;
      busy_A        = set_acc && (ctrl_busyReg == ctrl_readRegA);
    end
`endif
    if (ZR && (ctrl_readRegA == '0)) begin
      data_readRegA = '0;
      busy_A        = 1'b0;
    end
  end

  // Read port B: same structure as port A.
  always_comb begin
    data_readRegB = regs_q[ctrl_readRegB];
    busy_B        = busy_q[ctrl_readRegB];
`ifdef REGFILE_SB_BYPASS_EN
    if (wr_acc && (ctrl_writeReg == ctrl_readRegB)) begin
      data_readRegB = data_writeReg;
      busy_B        = set_acc && (ctrl_busyReg == ctrl_readRegB);
    end
`endif
    if (ZR && (ctrl_readRegB == '0)) begin
      data_readRegB = '0;
      busy_B        = 1'b0;
    end
  end

  assign clearing = (state_q == SWEEP);
  assign stall    = busy_A | busy_B | clearing;

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb (default parameters, ZERO_REG=1).
// Expected values come from a small reference model and flow through a scoreboard queue.
// Runs with or without REGFILE_SB_BYPASS_EN; same-cycle expectations follow the macro.
module tb_regfile_sb;
  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 32;

  logic          clock = 1'b0;
  logic          ctrl_reset_n;
  logic          ctrl_writeEnable;
  logic [AW-1:0] ctrl_writeReg;
  logic [DW-1:0] data_writeReg;
  logic [AW-1:0] ctrl_readRegA;
  logic [AW-1:0] ctrl_readRegB;
  logic [DW-1:0] data_readRegA;
  logic [DW-1:0] data_readRegB;
  logic          ctrl_setBusy;
  logic [AW-1:0] ctrl_busyReg;
  logic          busy_A;
  logic          busy_B;
  logic          ctrl_clear;
  logic          clearing;
  logic          stall;

  always #5 clock = ~clock;

  regfile_sb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ZERO_REG(1)) dut (
    .clock(clock), .ctrl_reset_n(ctrl_reset_n),
    .ctrl_writeEnable(ctrl_writeEnable), .ctrl_writeReg(ctrl_writeReg), .data_writeReg(data_writeReg),
    .ctrl_readRegA(ctrl_readRegA), .ctrl_readRegB(ctrl_readRegB),
    .data_readRegA(data_readRegA), .data_readRegB(data_readRegB),
    .ctrl_setBusy(ctrl_setBusy), .ctrl_busyReg(ctrl_busyReg),
    .busy_A(busy_A), .busy_B(busy_B),
    .ctrl_clear(ctrl_clear), .clearing(clearing), .stall(stall)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string         tag;
    logic [DW-1:0] val;
  } exp_t;
  exp_t exp_q[$];

  logic [DW-1:0] model_regs [DEPTH];
  logic          model_busy [DEPTH];

`ifdef REGFILE_SB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  task automatic check_val(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic sb_push(input string tag, input logic [DW-1:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    exp_q.push_back(e);
  endtask

  task automatic sb_pop_chk(input logic [DW-1:0] got);
    exp_t e;
    if (exp_q.size() == 0) begin
      e.tag = "sb_empty";
      e.val = 'x;
    end else begin
      e = exp_q.pop_front();
    end
    check_val(e.tag, got, e.val);
  endtask

  function automatic logic [DW-1:0] model_rd(input logic [AW-1:0] a);
    return (a == '0) ? '0 : model_regs[a];
  endfunction

  function automatic logic [DW-1:0] model_bz(input logic [AW-1:0] a);
    return (a == '0) ? '0 : {{(DW-1){1'b0}}, model_busy[a]};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      model_regs[i] = '0;
      model_busy[i] = 1'b0;
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    ctrl_writeEnable = 1'b0;
    ctrl_setBusy     = 1'b0;
    ctrl_clear       = 1'b0;
  endtask

  // Drive port A/B indices, settle away from the edge, compare data and busy against the model.
  task automatic chk_read(input string tag, input logic [AW-1:0] a, input logic [AW-1:0] b);
    ctrl_readRegA = a;
    ctrl_readRegB = b;
    sb_push({tag, "_dA"}, model_rd(a));
    sb_push({tag, "_dB"}, model_rd(b));
    sb_push({tag, "_bA"}, model_bz(a));
    sb_push({tag, "_bB"}, model_bz(b));
    #2;
    sb_pop_chk(data_readRegA);
    sb_pop_chk(data_readRegB);
    sb_pop_chk({{(DW-1){1'b0}}, busy_A});
    sb_pop_chk({{(DW-1){1'b0}}, busy_B});
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    ctrl_writeEnable = 1'b1;
    ctrl_writeReg    = a;
    data_writeReg    = d;
    tick();
    ctrl_writeEnable = 1'b0;
    if (a != '0) begin
      model_regs[a] = d;
      model_busy[a] = 1'b0;
    end
  endtask

  task automatic set_busy(input logic [AW-1:0] a);
    ctrl_setBusy = 1'b1;
    ctrl_busyReg = a;
    tick();
    ctrl_setBusy = 1'b0;
    if (a != '0) model_busy[a] = 1'b1;
  endtask

  task automatic chk_flag(input string tag, input logic got, input logic exp);
    sb_push(tag, {{(DW-1){1'b0}}, exp});
    sb_pop_chk({{(DW-1){1'b0}}, got});
  endtask

  initial begin
    int n;
    ctrl_reset_n  = 1'b0;
    idle_inputs();
    ctrl_writeReg = '0;
    data_writeReg = '0;
    ctrl_readRegA = '0;
    ctrl_readRegB = '0;
    ctrl_busyReg  = '0;
    model_reset();
    tick();
    tick();
    ctrl_reset_n = 1'b1;

    // Reset state across all indices.
    for (int i = 0; i < DEPTH; i++) begin
      tick();
      chk_read("rst_rd", AW'(i), AW'(DEPTH - 1 - i));
      chk_flag("rst_stall", stall, 1'b0);
    end
    chk_flag("rst_clearing", clearing, 1'b0);

    // Basic write, visible next cycle.
    wr(5'd5, 32'hDEADBEEF);
    chk_read("wr5", 5'd5, 5'd0);

    // Same-cycle read of a register being written.
    tick();
    ctrl_writeEnable = 1'b1;
    ctrl_writeReg    = 5'd9;
    data_writeReg    = 32'hA5A5A5A5;
    ctrl_readRegB    = 5'd9;
    sb_push("byp9_same", BYP ? 32'hA5A5A5A5 : model_rd(5'd9));
    #2;
    sb_pop_chk(data_readRegB);
    tick();
    ctrl_writeEnable = 1'b0;
    model_regs[9] = 32'hA5A5A5A5;
    chk_read("byp9_next", 5'd5, 5'd9);

    // Register 0 ignores writes and busy-set.
    ctrl_writeEnable = 1'b1;
    ctrl_writeReg    = 5'd0;
    data_writeReg    = 32'h12345678;
    ctrl_setBusy     = 1'b1;
    ctrl_busyReg     = 5'd0;
    chk_read("r0_same", 5'd0, 5'd0);
    tick();
    idle_inputs();
    chk_read("r0_next", 5'd0, 5'd9);
    chk_flag("r0_stall", stall, 1'b0);

    // Busy scoreboard on reg 7.
    set_busy(5'd7);
    chk_read("busy7", 5'd7, 5'd5);
    chk_flag("busy7_stall", stall, 1'b1);
    ctrl_writeEnable = 1'b1;
    ctrl_writeReg    = 5'd7;
    data_writeReg    = 32'h55;
    ctrl_readRegA    = 5'd7;
    sb_push("wr7_same_d", BYP ? 32'h55 : model_rd(5'd7));
    sb_push("wr7_same_b", BYP ? 32'h0 : 32'h1);
    #2;
    sb_pop_chk(data_readRegA);
    sb_pop_chk({{(DW-1){1'b0}}, busy_A});
    tick();
    ctrl_writeEnable = 1'b0;
    model_regs[7] = 32'h55;
    model_busy[7] = 1'b0;
    chk_read("wr7_next", 5'd7, 5'd0);
    ctrl_writeEnable = 1'b1;
    data_writeReg    = 32'h66;
    ctrl_setBusy     = 1'b1;
    ctrl_busyReg     = 5'd7;
    sb_push("setwr7_same_d", BYP ? 32'h66 : 32'h55);
    sb_push("setwr7_same_b", BYP ? 32'h1 : 32'h0);
    #2;
    sb_pop_chk(data_readRegA);
    sb_pop_chk({{(DW-1){1'b0}}, busy_A});
    tick();
    idle_inputs();
    model_regs[7] = 32'h66;
    model_busy[7] = 1'b1;
    chk_read("setwr7_next", 5'd7, 5'd9);

    // Fill 1..31 with index, then sweep.
    for (int i = 1; i < DEPTH; i++) wr(AW'(i), DW'(i));
    chk_read("fill", 5'd31, 5'd3);
    ctrl_clear = 1'b1;
    tick();
    ctrl_clear = 1'b0;
    n = 0;
    while (clearing && n < 100) begin
      n++;
      idle_inputs();
      if (n == 1) chk_flag("sweep_stall", stall, 1'b1);
      if (n == 5) begin
        chk_read("sweep_partial", 5'd20, 5'd2);
        ctrl_writeEnable = 1'b1;
        ctrl_writeReg    = 5'd3;
        data_writeReg    = 32'hBAD;
      end
      if (n == 10) begin
        ctrl_clear   = 1'b1;
        ctrl_setBusy = 1'b1;
        ctrl_busyReg = 5'd2;
      end
      if (n < 3 || n > 20) model_regs[n] = model_regs[n];
      tick();
      // The reference clears one register per sweep cycle starting at 1.
      model_regs[n] = '0;
      model_busy[n] = 1'b0;
    end
    idle_inputs();
    check_val("clear_cycles", DW'(n), 32'd31);
    model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      tick();
      chk_read("post_sweep", AW'(i), 5'd2);
    end
    chk_flag("post_sweep_clearing", clearing, 1'b0);

    // Reset asserted between edges during a sweep.
    for (int i = 1; i < DEPTH; i++) wr(AW'(i), 32'h01010101 * i);
    set_busy(5'd12);
    set_busy(5'd25);
    ctrl_clear = 1'b1;
    tick();
    ctrl_clear = 1'b0;
    tick();
    tick();
    chk_flag("pre_abort_clearing", clearing, 1'b1);
    #2;
    ctrl_reset_n = 1'b0;
    model_reset();
    #1;
    chk_flag("abort_clearing", clearing, 1'b0);
    for (int i = 0; i < DEPTH; i++) begin
      tick();
      chk_read("abort_rd", AW'(i), AW'(DEPTH - 1 - i));
    end
    ctrl_readRegA = 5'd12;
    ctrl_readRegB = 5'd25;
    #1;
    chk_flag("abort_stall", stall, 1'b0);
    tick();
    ctrl_reset_n = 1'b1;
    tick();
    tick();
    chk_flag("after_rst_clearing", clearing, 1'b0);
    chk_read("after_rst", 5'd12, 5'd25);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, checks=%0d", checks);
    $fatal(1, "timeout");
  end
endmodule
